// File: rtl/axi4_lite_read_arbiter_if.sv
// Bundle of signals between the read arbiter, its requesters and the
// downstream AXI4-Lite read port.
//   req_*  : requester-facing AR and R channels (packed per requester)
//   m_*    : single bus-facing AR and R channels
// Modports:
//   master : arbiter view (drives req_arready/req_r*, m_ar*, m_rready)
//   slave  : environment view (requesters plus downstream slave)
interface axi4_lite_read_arbiter_if #(
    parameter int NUM_REQ       = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_araddr;
    logic [NUM_REQ*3-1:0]             req_arprot;
    logic [NUM_REQ-1:0]               req_arvalid;
    logic [NUM_REQ-1:0]               req_arready;
    logic [DATA_WIDTH-1:0]            req_rdata;
    logic [1:0]                       req_rresp;
    logic [NUM_REQ-1:0]               req_rvalid;
    logic [NUM_REQ-1:0]               req_rready;

    logic [ADDRESS_WIDTH-1:0]         m_araddr;
    logic [2:0]                       m_arprot;
    logic                             m_arvalid;
    logic                             m_arready;
    logic [DATA_WIDTH-1:0]            m_rdata;
    logic [1:0]                       m_rresp;
    logic                             m_rvalid;
    logic                             m_rready;

    modport master (
        input  req_araddr, req_arprot, req_arvalid, req_rready,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        output req_arready, req_rdata, req_rresp, req_rvalid,
        output m_araddr, m_arprot, m_arvalid, m_rready
    );

    modport slave (
        output req_araddr, req_arprot, req_arvalid, req_rready,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        input  req_arready, req_rdata, req_rresp, req_rvalid,
        input  m_araddr, m_arprot, m_arvalid, m_rready
    );
endinterface

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-Lite read master port between NUM_REQ requesters.
// Round-robin arbitration on AR; an in-order grant FIFO remembers which
// requester owns each outstanding read and steers R beats back to it.
// Ports:
//   aclk, areset     : clock, synchronous active-high reset
//   bus              : requester and downstream AR/R channels (master modport)
//   outstanding      : grant FIFO occupancy (accepted, not yet answered)
//   err_unexpected_r : sticky flag, R beat arrived with nothing outstanding
module axi4_lite_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 10
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    axi4_lite_read_arbiter_if.master             bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_unexpected_r
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

    typedef enum logic {
        IDLE,
        ISSUE
    } ar_state_t;

    ar_state_t                state, state_nxt;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_found;
    logic [NUM_REQ-1:0]       arready;
    logic                     push;
    logic                     pop;
    logic                     can_accept;

    logic [IDX_W-1:0]         fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic [IDX_W-1:0]         head;
    logic [NUM_REQ-1:0]       rvalid;
    logic                     rready;

    logic [ADDRESS_WIDTH-1:0] araddr_q;
    logic [2:0]               arprot_q;

    // Pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin : grant_search
        logic [IDX_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_arvalid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // R routing: the FIFO head owns whatever beat is on the bus.
    always_comb begin
        head   = fifo_mem[rd_ptr];
        rvalid = '0;
        if (!empty) begin
            rvalid[head] = bus.m_rvalid;
        end
        rready = !empty && bus.req_rready[head];
        pop    = bus.m_rvalid && rready;
    end

    assign empty = (count == '0);

    // A pop in this cycle frees a slot for a same-cycle capture, so a
    // full FIFO can still accept while draining.
    assign can_accept = (count < CNT_W'(MAX_OUTSTANDING)) || pop;

    always_comb begin
        state_nxt = state;
        arready   = '0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && can_accept) begin
                    arready[grant_idx] = 1'b1;
                    push               = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_arready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state; the FIFO entry is counted at capture time so an R
    // beat can never arrive ahead of its owner record.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= IDLE;
            rr_ptr           <= IDX_W'(NUM_REQ-1);
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            err_unexpected_r <= 1'b0;
            araddr_q         <= '0;
            arprot_q         <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                rr_ptr   <= grant_idx;
                araddr_q <= bus.req_araddr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                arprot_q <= bus.req_arprot[grant_idx*3 +: 3];
                wr_ptr   <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.m_rvalid && empty) begin
                err_unexpected_r <= 1'b1;
            end
        end
    end

    // Owner records carry no reset; the pointers define which are live.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant_idx;
        end
    end

    assign bus.req_arready = arready;
    assign bus.req_rvalid  = rvalid;
    assign bus.req_rdata   = bus.m_rdata;
    assign bus.req_rresp   = bus.m_rresp;
    assign bus.m_araddr    = araddr_q;
    assign bus.m_arprot    = arprot_q;
    assign bus.m_arvalid   = (state == ISSUE);
    assign bus.m_rready    = rready;
    assign outstanding     = count;
endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
module tb_axi4_lite_read_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 10;

    logic aclk;
    logic areset;
    logic [$clog2(MO+1)-1:0] outstanding;
    logic err_unexpected_r;

    axi4_lite_read_arbiter_if #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_read_arbiter #(
        .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .bus(bus),
        .outstanding(outstanding),
        .err_unexpected_r(err_unexpected_r)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req_araddr  = '0;
        bus.req_arprot  = '0;
        bus.req_arvalid = '0;
        bus.req_rready  = '0;
        bus.m_arready   = 1'b0;
        bus.m_rdata     = '0;
        bus.m_rresp     = 2'b00;
        bus.m_rvalid    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  arvalid;
        logic        m_arready;
        logic        m_rvalid;
        logic [1:0]  rready;
        logic [31:0] rdata;
        logic [1:0]  x_arready;
        logic        x_arvalid;
        logic [31:0] x_araddr;
        logic [1:0]  x_rvalid;
        logic        x_rready;
        int          x_out;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] av, input logic mar, input logic mrv,
                                input logic [1:0] rr, input logic [31:0] rd,
                                input logic [1:0] xar, input logic xav, input logic [31:0] xad,
                                input logic [1:0] xrv, input logic xrr, input int xo);
        vec_t v;
        v.arvalid = av; v.m_arready = mar; v.m_rvalid = mrv; v.rready = rr; v.rdata = rd;
        v.x_arready = xar; v.x_arvalid = xav; v.x_araddr = xad;
        v.x_rvalid = xrv; v.x_rready = xrr; v.x_out = xo;
        return v;
    endfunction

    vec_t tbl[19];

    // Random-phase reference model state
    int          q[$];
    int          last;
    bit          busy;
    logic [31:0] baddr;
    logic [2:0]  bprot;
    logic [31:0] ra[NR];
    logic [2:0]  rp[NR];
    logic [NR-1:0] av;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Fairness from a fresh reset (requester 0 first), then in-order drain.
        tbl[0]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b01, 0, 0,         2'b00, 0, 0);
        tbl[1]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h1000,  2'b00, 0, 1);
        tbl[2]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b10, 0, 0,         2'b00, 0, 1);
        tbl[3]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h2000,  2'b00, 0, 2);
        tbl[4]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b01, 0, 0,         2'b00, 0, 2);
        tbl[5]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h1000,  2'b00, 0, 3);
        tbl[6]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b10, 0, 0,         2'b00, 0, 3);
        tbl[7]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h2000,  2'b00, 0, 4);
        tbl[8]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b01, 0, 0,         2'b00, 0, 4);
        tbl[9]  = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h1000,  2'b00, 0, 5);
        tbl[10] = mk(2'b11, 1, 0, 2'b00, 0, 2'b10, 0, 0,         2'b00, 0, 5);
        tbl[11] = mk(2'b11, 1, 0, 2'b00, 0, 2'b00, 1, 32'h2000,  2'b00, 0, 6);
        tbl[12] = mk(2'b00, 0, 1, 2'b11, 32'hA0, 2'b00, 0, 0,    2'b01, 1, 6);
        tbl[13] = mk(2'b00, 0, 1, 2'b11, 32'hA1, 2'b00, 0, 0,    2'b10, 1, 5);
        tbl[14] = mk(2'b00, 0, 1, 2'b11, 32'hA2, 2'b00, 0, 0,    2'b01, 1, 4);
        tbl[15] = mk(2'b00, 0, 1, 2'b11, 32'hA3, 2'b00, 0, 0,    2'b10, 1, 3);
        tbl[16] = mk(2'b00, 0, 1, 2'b11, 32'hA4, 2'b00, 0, 0,    2'b01, 1, 2);
        tbl[17] = mk(2'b00, 0, 1, 2'b11, 32'hA5, 2'b00, 0, 0,    2'b10, 1, 1);
        tbl[18] = mk(2'b00, 0, 0, 2'b11, 0,      2'b00, 0, 0,    2'b00, 0, 0);

        areset = 1'b1;
        clear_inputs();
        tick();
        tick();
        areset = 1'b0;
        #1;
        chk("rst_m_arvalid", bus.m_arvalid, 0);
        chk("rst_m_araddr", bus.m_araddr, 0);
        chk("rst_m_arprot", bus.m_arprot, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected_r, 0);
        chk("rst_m_rready", bus.m_rready, 0);

        // Table-driven vectors
        bus.req_araddr = {32'h2000, 32'h1000};
        bus.req_arprot = {3'b101, 3'b010};
        foreach (tbl[i]) begin
            bus.req_arvalid = tbl[i].arvalid;
            bus.m_arready   = tbl[i].m_arready;
            bus.m_rvalid    = tbl[i].m_rvalid;
            bus.req_rready  = tbl[i].rready;
            bus.m_rdata     = tbl[i].rdata;
            #1;
            chk($sformatf("tbl%0d_arready", i), bus.req_arready, tbl[i].x_arready);
            chk($sformatf("tbl%0d_m_arvalid", i), bus.m_arvalid, tbl[i].x_arvalid);
            if (tbl[i].x_arvalid) chk($sformatf("tbl%0d_m_araddr", i), bus.m_araddr, tbl[i].x_araddr);
            chk($sformatf("tbl%0d_rvalid", i), bus.req_rvalid, tbl[i].x_rvalid);
            chk($sformatf("tbl%0d_m_rready", i), bus.m_rready, tbl[i].x_rready);
            chk($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].x_out);
            if (tbl[i].m_rvalid) chk($sformatf("tbl%0d_rdata", i), bus.req_rdata, tbl[i].rdata);
            tick();
        end

        // Single read
        do_reset();
        bus.req_arvalid = 2'b01;
        bus.req_araddr[31:0] = 32'h0000_1000;
        bus.req_arprot[2:0]  = 3'b010;
        #1;
        chk("single_arready", bus.req_arready, 2'b01);
        chk("single_m_arvalid_pre", bus.m_arvalid, 0);
        tick();
        bus.req_arvalid = 2'b00;
        #1;
        chk("single_m_arvalid", bus.m_arvalid, 1);
        chk("single_m_araddr", bus.m_araddr, 32'h0000_1000);
        chk("single_m_arprot", bus.m_arprot, 3'b010);
        chk("single_out1", outstanding, 1);
        bus.m_arready = 1'b1;
        tick();
        bus.m_arready  = 1'b0;
        bus.m_rvalid   = 1'b1;
        bus.m_rdata    = 32'hDEAD_BEEF;
        bus.m_rresp    = 2'b00;
        bus.req_rready = 2'b11;
        #1;
        chk("single_rvalid", bus.req_rvalid, 2'b01);
        chk("single_rdata", bus.req_rdata, 32'hDEAD_BEEF);
        chk("single_rresp", bus.req_rresp, 2'b00);
        chk("single_m_rready", bus.m_rready, 1);
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        chk("single_out0", outstanding, 0);
        chk("single_m_arvalid_post", bus.m_arvalid, 0);

        // Ordering: req1 then req0, responses routed in issue order
        bus.req_arvalid = 2'b10;
        bus.req_araddr[63:32] = 32'h20;
        #1;
        chk("ord_arready1", bus.req_arready, 2'b10);
        tick();
        bus.req_arvalid = 2'b00;
        bus.m_arready   = 1'b1;
        #1;
        chk("ord_araddr1", bus.m_araddr, 32'h20);
        tick();
        bus.m_arready   = 1'b0;
        bus.req_arvalid = 2'b01;
        bus.req_araddr[31:0] = 32'h10;
        #1;
        chk("ord_arready0", bus.req_arready, 2'b01);
        tick();
        bus.req_arvalid = 2'b00;
        bus.m_arready   = 1'b1;
        #1;
        chk("ord_araddr0", bus.m_araddr, 32'h10);
        tick();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'h1111;
        #1;
        chk("ord_rvalid_first", bus.req_rvalid, 2'b10);
        chk("ord_rdata_first", bus.req_rdata, 32'h1111);
        tick();
        bus.m_rdata = 32'h2222;
        #1;
        chk("ord_rvalid_second", bus.req_rvalid, 2'b01);
        chk("ord_rdata_second", bus.req_rdata, 32'h2222);
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        chk("ord_out0", outstanding, 0);

        // Full: 10 reads with no R beats, then pop-while-full
        do_reset();
        bus.req_arvalid = 2'b01;
        for (int i = 0; i < MO; i++) begin
            #1;
            chk($sformatf("full_fill%0d_arready", i), bus.req_arready, 2'b01);
            tick();
            bus.m_arready = 1'b1;
            tick();
            bus.m_arready = 1'b0;
        end
        #1;
        chk("full_outstanding", outstanding, MO);
        chk("full_arready", bus.req_arready, 2'b00);
        tick();
        #1;
        chk("full_arready_hold", bus.req_arready, 2'b00);
        bus.m_rvalid   = 1'b1;
        bus.req_rready = 2'b01;
        bus.m_rdata    = 32'h5555;
        #1;
        chk("full_pop_arready", bus.req_arready, 2'b01);
        chk("full_pop_m_rready", bus.m_rready, 1);
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        chk("full_pop_outstanding", outstanding, MO);
        chk("full_pop_m_arvalid", bus.m_arvalid, 1);
        bus.req_arvalid = 2'b00;
        bus.m_arready   = 1'b1;
        tick();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b1;
        repeat (MO) tick();
        bus.m_rvalid = 1'b0;
        #1;
        chk("full_drain_out", outstanding, 0);

        // Backpressure with SLVERR
        do_reset();
        bus.req_arvalid = 2'b10;
        bus.req_araddr[63:32] = 32'h40;
        tick();
        bus.req_arvalid = 2'b00;
        bus.m_arready   = 1'b1;
        tick();
        bus.m_arready  = 1'b0;
        bus.m_rvalid   = 1'b1;
        bus.m_rresp    = 2'b10;
        bus.m_rdata    = 32'hCAFE_0001;
        bus.req_rready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_m_rready", i), bus.m_rready, 0);
            chk($sformatf("bp%0d_rvalid", i), bus.req_rvalid, 2'b10);
            chk($sformatf("bp%0d_rdata", i), bus.req_rdata, 32'hCAFE_0001);
            chk($sformatf("bp%0d_out", i), outstanding, 1);
            tick();
        end
        bus.req_rready = 2'b10;
        #1;
        chk("bp_release_m_rready", bus.m_rready, 1);
        chk("bp_release_rresp", bus.req_rresp, 2'b10);
        tick();
        bus.m_rvalid   = 1'b0;
        bus.req_rready = 2'b00;
        #1;
        chk("bp_out0", outstanding, 0);

        // Reset mid-ISSUE, then unexpected R beat
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req_arvalid = 2'b01;
            tick();
            bus.req_arvalid = 2'b00;
            if (i < 2) begin
                bus.m_arready = 1'b1;
                tick();
                bus.m_arready = 1'b0;
            end
        end
        #1;
        chk("rstmid_out3", outstanding, 3);
        chk("rstmid_issue", bus.m_arvalid, 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        chk("rstmid_m_arvalid", bus.m_arvalid, 0);
        chk("rstmid_out0", outstanding, 0);
        bus.m_rvalid   = 1'b1;
        bus.req_rready = 2'b11;
        #1;
        chk("unexp_m_rready", bus.m_rready, 0);
        chk("unexp_rvalid", bus.req_rvalid, 2'b00);
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        chk("unexp_err_set", err_unexpected_r, 1);
        repeat (3) tick();
        #1;
        chk("unexp_err_sticky", err_unexpected_r, 1);
        do_reset();
        #1;
        chk("unexp_err_cleared", err_unexpected_r, 0);

        // Randomized traffic against a queue-based reference model
        do_reset();
        q.delete();
        last = NR - 1;
        busy = 1'b0;
        baddr = '0;
        bprot = '0;
        av = '0;
        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rp[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            int gr;
            bit pop_e;
            logic [NR-1:0] rr_v;
            for (int i = 0; i < NR; i++) begin
                if (!av[i] && $urandom_range(0, 2) == 0) begin
                    av[i] = 1'b1;
                    ra[i] = $urandom;
                    rp[i] = 3'($urandom_range(0, 7));
                end
                bus.req_araddr[i*AW +: AW] = ra[i];
                bus.req_arprot[i*3 +: 3]   = rp[i];
            end
            rr_v            = NR'($urandom);
            bus.req_arvalid = av;
            bus.req_rready  = rr_v;
            bus.m_arready   = 1'($urandom_range(0, 1));
            bus.m_rvalid    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.m_rdata     = $urandom;
            bus.m_rresp     = 2'($urandom_range(0, 3));

            pop_e = bus.m_rvalid && (q.size() > 0) && rr_v[q[0]];
            gr = -1;
            if (!busy && (q.size() < MO || pop_e)) begin
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (last + k) % NR;
                    if (gr < 0 && av[c]) gr = c;
                end
            end
            #1;
            chk("rnd_arready", bus.req_arready, (gr >= 0) ? (64'd1 << gr) : 64'd0);
            chk("rnd_m_arvalid", bus.m_arvalid, busy);
            if (busy) begin
                chk("rnd_m_araddr", bus.m_araddr, baddr);
                chk("rnd_m_arprot", bus.m_arprot, bprot);
            end
            chk("rnd_rvalid", bus.req_rvalid,
                (q.size() > 0 && bus.m_rvalid) ? (64'd1 << q[0]) : 64'd0);
            chk("rnd_m_rready", bus.m_rready, (q.size() > 0) ? rr_v[q[0]] : 1'b0);
            chk("rnd_outstanding", outstanding, q.size());
            if (bus.m_rvalid) begin
                chk("rnd_rdata", bus.req_rdata, bus.m_rdata);
                chk("rnd_rresp", bus.req_rresp, bus.m_rresp);
            end
            tick();
            if (busy && bus.m_arready) busy = 1'b0;
            if (pop_e) void'(q.pop_front());
            if (gr >= 0) begin
                q.push_back(gr);
                busy  = 1'b1;
                baddr = ra[gr];
                bprot = rp[gr];
                last  = gr;
                av[gr] = 1'b0;
            end
        end
        #1;
        chk("rnd_err_clear", err_unexpected_r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_read_arbiter.md
Name: axi4_lite_read_arbiter

Overview:
Shares one AXI4-Lite read master port between NUM_REQ requesters. Round-robin arbitration on the read address channel. An in-order grant FIFO tracks outstanding reads and routes each read data beat back to the requester that issued it. Sits between the read-master sequencing logic of several agents/engines and the single bus-facing read interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDRESS_WIDTH, 32, araddr width
DATA_WIDTH, 32, rdata width
MAX_OUTSTANDING, 10, maximum accepted-but-unanswered reads (1..16; need not be a power of two)

Ports:
aclk  in  1  clock
areset  in  1  reset; synchronous, active-high
req_araddr  in  NUM_REQ*ADDRESS_WIDTH  per-requester address; slice i = requester i
req_arprot  in  NUM_REQ*3  per-requester arprot
req_arvalid  in  NUM_REQ  per-requester address valid
req_arready  out  NUM_REQ  per-requester address accept
req_rdata  out  DATA_WIDTH  read data, broadcast to all requesters
req_rresp  out  2  read response, broadcast (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
req_rvalid  out  NUM_REQ  per-requester data valid
req_rready  in  NUM_REQ  per-requester data ready
m_araddr  out  ADDRESS_WIDTH  downstream address
m_arprot  out  3  downstream arprot
m_arvalid  out  1  downstream address valid (registered)
m_arready  in  1  downstream address ready
m_rdata  in  DATA_WIDTH  downstream read data
m_rresp  in  2  downstream response
m_rvalid  in  1  downstream data valid
m_rready  out  1  downstream data ready
outstanding  out  $clog2(MAX_OUTSTANDING+1)  current grant-FIFO occupancy
err_unexpected_r  out  1  sticky: m_rvalid seen while FIFO empty

Behaviour:
- Reset (areset=1 at a clock edge) clears all state:
  - m_arvalid=0, m_araddr=0, m_arprot=0, outstanding=0, err_unexpected_r=0, FIFO pointers=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-transaction drops all in-flight bookkeeping; no completion is emitted.
- AR FSM states:
  - IDLE: m_arvalid=0.
  - ISSUE: m_arvalid=1; m_araddr/m_arprot are held stable.
- IDLE:
  - grant = first i with req_arvalid[i]=1, searching upward from (rr_ptr+1) mod NUM_REQ.
  - req_arready[grant]=1 combinationally when outstanding<MAX_OUTSTANDING. All other req_arready bits are 0.
  - On req_arvalid&req_arready: capture araddr/arprot, push grant index into the FIFO, set rr_ptr=grant, go to ISSUE.
  - m_arvalid rises the next cycle, so AR latency is 1 cycle.
- ISSUE:
  - All req_arready=0.
  - Stay until m_arvalid&m_arready, then return to IDLE.
  - The next grant can occur in the cycle after the handshake, giving a max AR throughput of 1 per 2 cycles.
- Full: when outstanding==MAX_OUTSTANDING, all req_arready=0. A requester's arvalid waits without any loss.
- R routing (combinational):
  - head = FIFO head index.
  - req_rvalid[head] = m_rvalid & !empty; all other req_rvalid bits = 0.
  - m_rready = req_rready[head] & !empty.
  - req_rdata/req_rresp = m_rdata/m_rresp; rresp passes through unchanged, including SLVERR/DECERR.
  - On m_rvalid&m_rready: pop the FIFO.
- Occupancy:
  - outstanding increments on push and decrements on pop.
  - Push and pop in the same cycle leave it unchanged. This is legal even when full: the pop frees the entry in that same cycle's arready evaluation, so arready may assert on pop-while-full.
- FIFO pointers wrap at MAX_OUTSTANDING, not at a power of two.
- Empty: m_rvalid=1 with an empty FIFO sets err_unexpected_r, which stays set until reset. m_rready=0 in that case.
- Occupancy counts from AR capture, not from the m_arready handshake. This guarantees an R beat can never precede its FIFO entry.
- A requester whose arvalid stays high is granted at most once per NUM_REQ grants while others are requesting.

Test Plan:
- Single read: req0 araddr=0x0000_1000, arprot=3'b010. → m_arvalid rises 1 cycle after req_arready[0]. The slave returns rdata=0xDEAD_BEEF, rresp=00. → Only req_rvalid[0] pulses, outstanding goes 1→0.
- Fairness: NUM_REQ=2, both requesters hold arvalid for 6 grants, slave returns m_arready=1 immediately. → Grant order is 0,1,0,1,0,1.
- Ordering: req1 reads 0x20, then req0 reads 0x10. Responses 0x1111 then 0x2222 arrive in order. → 0x1111 goes to req1, 0x2222 goes to req0, and no beat is misrouted.
- Full: issue 10 reads with no R beats. → outstanding=10 and all req_arready stay 0 while req0 still asserts arvalid. One R pop in a cycle where req0 arvalid=1. → req_arready[0]=1 in that same cycle, and outstanding stays 10.
- Backpressure and error: req1 holds rready=0 for 5 cycles while m_rvalid=1 with rresp=10. → m_rready=0 throughout and rdata is held. rready rises. → Pop occurs and req1 sees rresp=SLVERR.
- Reset and unexpected data: areset mid-ISSUE with outstanding=3. → The next cycle shows m_arvalid=0 and outstanding=0. Then m_rvalid=1 with an empty FIFO. → err_unexpected_r=1, m_rready=0, and the flag stays set until the next areset.
